// File: rtl/efpga_gold_counter.sv
// Golden reference for the eFPGA equivalence design: 16-bit up/down counter plus an 8-bit
// maximal-length LFSR on a 28-pad bank. The LFSR exists only when GOLD_LFSR_EN is defined.
module efpga_gold_counter (
    input  logic        clk,
    input  logic [27:0] io_in,
    output logic [27:0] io_out,
    output logic [27:0] io_oeb
);

    logic        w_rst;
    logic        w_hold;
    logic        w_dir;
    logic        w_unused;
    logic [15:0] r_ctr;

    assign w_rst    = io_in[0];
    assign w_hold   = io_in[1];
    assign w_dir    = io_in[2];
    assign w_unused = ^io_in[27:3];

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_ctr <= 16'h0000;
        end else if (!w_hold) begin
            if (w_dir) begin
                r_ctr <= r_ctr - 16'h0001;
            end else begin
                r_ctr <= r_ctr + 16'h0001;
            end
        end
    end

`ifdef GOLD_LFSR_EN
    logic [7:0] r_lfsr;
    logic       w_fb;

    // Taps for x^8+x^6+x^5+x^4+1: period 255, the all-zero state is unreachable.
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_lfsr <= 8'h01;
        end else if (!w_hold) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign io_out = {r_ctr, r_lfsr, 4'h0};
    assign io_oeb = 28'h000000F;
`else
    assign io_out = {r_ctr, 8'h00, 4'h0};
    assign io_oeb = 28'h0000FFF;
`endif

endmodule

// File: tb/tb_efpga_gold_counter.sv
// Scoreboard bench for efpga_gold_counter: random reset/hold/direction stimulus checked
// against an arithmetic counter and a table-driven LFSR sequence model.
module tb_efpga_gold_counter;

    logic        clk = 1'b0;
    logic [27:0] io_in = 28'h0000001;
    logic [27:0] io_out;
    logic [27:0] io_oeb;

    efpga_gold_counter dut (
        .clk    (clk),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [27:0] sb_out[$];
    logic [27:0] sb_oeb[$];

    // Model state: counter as an integer, LFSR as a position in its 255-long sequence.
    int       m_ctr = 0;
    int       m_pos = 0;
    logic [7:0] seq[255];

`ifdef GOLD_LFSR_EN
    localparam logic [27:0] OebExp = 28'h000000F;
`else
    localparam logic [27:0] OebExp = 28'h0000FFF;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_lfsr();
`ifdef GOLD_LFSR_EN
        return seq[m_pos];
`else
        return 8'h00;
`endif
    endfunction

    // One clock cycle with the given control pins; unused pins get random junk.
    task automatic step(input logic rst, input logic hold, input logic dir);
        logic [24:0] junk;
        junk  = 25'($urandom);
        io_in = {junk, dir, hold, rst};
        @(posedge clk);
        if (rst) begin
            m_ctr = 0;
            m_pos = 0;
        end else if (!hold) begin
            m_ctr = dir ? (m_ctr + 65535) % 65536 : (m_ctr + 1) % 65536;
            m_pos = (m_pos + 1) % 255;
        end
        #1;
        sb_out.push_back({m_ctr[15:0], m_lfsr(), 4'h0});
        sb_oeb.push_back(OebExp);
    endtask

    always @(negedge clk) begin
        if (sb_out.size() > 0) begin
            chk("sb_out", {4'h0, io_out}, {4'h0, sb_out.pop_front()});
            chk("sb_oeb", {4'h0, io_oeb}, {4'h0, sb_oeb.pop_front()});
`ifdef GOLD_LFSR_EN
            if (io_out[11:4] == 8'h00) chk("lfsr_nonzero", 32'(io_out[11:4]), 32'hFF);
`endif
        end
    end

    initial begin
        logic [7:0] v;
        logic [7:0] t1_lfsr[6];
        logic [15:0] t3_ctr[3];
        logic [15:0] frozen;

        // Sequence table straight from the polynomial x^8+x^6+x^5+x^4+1.
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            seq[i] = v;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
`ifdef GOLD_LFSR_EN
        t1_lfsr = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
`else
        t1_lfsr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        t3_ctr = '{16'hFFFF, 16'hFFFE, 16'hFFFD};

        // Reset for 5 cycles, then count up from release.
        repeat (5) step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_ctr", 32'(io_out[27:12]), 32'h0);
        chk("reset_oeb", {4'h0, io_oeb}, {4'h0, OebExp});
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk("t1_ctr", 32'(io_out[27:12]), 32'(k + 1));
            chk("t1_lfsr", 32'(io_out[11:4]), 32'(t1_lfsr[k]));
        end

        // Hold for 10 cycles mid-run, then resume without skipping.
        frozen = io_out[27:12];
        repeat (10) step(1'b0, 1'b1, $urandom_range(0, 1) == 1);
        @(negedge clk);
        chk("t2_frozen", 32'(io_out[27:12]), 32'(frozen));
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_resume", 32'(io_out[27:12]), 32'(frozen + 16'h1));

        // Count down across the zero boundary.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1);
            @(negedge clk);
            chk("t3_down", 32'(io_out[27:12]), 32'(t3_ctr[k]));
        end

        // Reset wins over hold and direction.
        repeat (7) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("t5_ctr", 32'(io_out[27:12]), 32'h0);
        chk("t5_lfsr", 32'(io_out[11:4]), 32'(m_lfsr()));
`ifdef GOLD_LFSR_EN
        chk("t5_lfsr01", 32'(io_out[11:4]), 32'h01);
`endif

        // Random mix of hold, direction and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1);
        end

        // Full up-count wrap: 65536 edges from reset return the counter to zero.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 65536; i++) begin
            step(1'b0, 1'b0, 1'b0);
`ifdef GOLD_LFSR_EN
            if (i % 255 == 0) begin
                @(negedge clk);
                chk("t4_lfsr_period", 32'(io_out[11:4]), 32'h01);
            end
`endif
        end
        @(negedge clk);
        chk("t4_wrap", 32'(io_out[27:12]), 32'h0);

        @(negedge clk);
        chk("sb_drained", 32'(sb_out.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/efpga_gold_counter.md
# efpga_gold_counter

Golden user design for eFPGA fabric equivalence checks. It runs a 16-bit up/down counter and an 8-bit maximal-length LFSR, and drives them onto a 28-bit user I/O bank with fixed output enables. The same function is placed-and-routed into the fabric. The bench compares the fabric's pad outputs and tristate enables against this block cycle by cycle.

## Interface
Parameters: none. Widths are fixed.

- clk  input  1  Single clock. All state updates on its rising edge.
- io_in  input  28  Pad inputs.
  - io_in[0] is the reset: synchronous, active-high.
  - io_in[1] is hold.
  - io_in[2] is direction.
  - io_in[27:3] are ignored.
- io_out  output  28  Pad output values.
- io_oeb  output  28  Per-pad output-enable, active-low. 0 means the pad is driven. The fabric's T signal equals ~io_oeb.

Reset is on io_in[0]; there is no separate reset port.

## Operation
Registers:
- ctr[15:0]
- lfsr[7:0]

Priority at each rising clk edge:
1. io_in[0]=1 (reset): ctr←16'h0000, lfsr←8'h01.
2. Otherwise, io_in[1]=1 (hold): ctr and lfsr keep their values.
3. Otherwise:
   - ctr←ctr+1 when io_in[2]=0; ctr←ctr−1 when io_in[2]=1. Both are modulo 2^16.
   - lfsr←{lfsr[6:0], fb}, where fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]. This is x^8+x^6+x^5+x^4+1, period 255, and never reaches 8'h00.

Output mapping:
- io_out[27:12] = ctr.
- io_out[11:4] = lfsr. Compiled-out variant: see Configuration.
- io_out[3:0] = 4'h0. These pads are inputs.
- io_oeb: constant, purely combinational. Bits [27:4]=0 (driven) and [3:0]=1, i.e. 28'h000000F.
- No X or Z may appear on io_out or io_oeb after the first reset.

Boundary behaviour:
- Wrap-around: up from 16'hFFFF gives 16'h0000; down from 16'h0000 gives 16'hFFFF. No flags.
- Reset has priority over hold and direction.
- Reset asserted mid-count takes effect at the next edge, regardless of the other inputs.
- Direction changes take effect on the next non-hold edge. There is no pipeline.
- Register state before the first reset is unspecified. The environment must apply reset for at least 1 cycle before checking.

## Timing
- All outputs are registered: latency is 1 clk from input sample to output change. io_oeb is static.
- After reset deasserts, the first rising edge gives ctr=1 and lfsr=8'h02.
- Inputs are sampled at the rising edge. Setup and hold are relative to clk only.
- Outputs must be stable at the falling edge; the bench samples there.
- No handshake and no multi-cycle paths.

## Configuration
- GOLD_LFSR_EN defined: the LFSR is present as described above, and io_oeb=28'h000000F.
- GOLD_LFSR_EN undefined: there is no lfsr register.
  - io_out[11:4]=8'h00.
  - io_oeb[11:4]=1, so io_oeb=28'h0000FFF.
  - The counter behaviour is unchanged.
- The fabric bitstream must be built from the same setting as this block.

## Test plan
1. io_in=1 for 5 cycles, then io_in=0. Sample at the falling edge of the first six cycles after release → io_out[27:12]=1,2,3,4,5,6 and io_out[11:4]=02,04,08,11,23,47 (hex). io_oeb=28'h000000F throughout.
2. Apply io_in[1]=1 for 10 cycles mid-run → ctr and lfsr are frozen. After release, counting resumes from the frozen values with no skipped states.
3. Reset, then io_in[2]=1 → io_out[27:12] reads FFFF, FFFE, FFFD after the 1st, 2nd and 3rd edges.
4. Count up 65,536 cycles from reset → ctr returns to 0000. lfsr returns to 8'h01 every 255 non-hold cycles and is never 8'h00.
5. Assert io_in[0] together with io_in[1]=1 and io_in[2]=1 → the next edge gives ctr=0000 and lfsr=01.
6. Build with GOLD_LFSR_EN undefined → io_out[11:4]=00 and io_oeb=28'h0000FFF. Counter results from tests 1 and 3 are unchanged.
